// File: rtl/opendap_mem_ap_pkg.sv
// -----------------------------------------------------------------------------
// opendap_mem_ap_pkg
// Purpose : shared definitions for the MEM-AP. Holds the register word
//           addresses, CSW field positions, transfer size encodings, FSM state
//           encodings and the registered bus command payload.
// Ports   : none (package).
// Config  : OPENDAP_MEM_AP_SUB_WORD_EN selects byte/halfword support in the
//           files that import this package.
// -----------------------------------------------------------------------------
package opendap_mem_ap_pkg;

   // Register word addresses {APBANKSEL, A[3:2]}
   localparam logic [5:0] REG_CSW  = 6'h00;
   localparam logic [5:0] REG_TAR  = 6'h01;
   localparam logic [5:0] REG_DRW  = 6'h03;
   localparam logic [5:0] REG_CFG  = 6'h3D;
   localparam logic [5:0] REG_BASE = 6'h3E;
   localparam logic [5:0] REG_IDR  = 6'h3F;

   // BD0-BD3 occupy 0x04-0x07
   localparam logic [3:0] REG_BD_BANK = 4'h1;

   // CSW field positions
   localparam int unsigned CSW_SIZE_LSB  = 0;
   localparam int unsigned CSW_INC_LSB   = 4;
   localparam int unsigned CSW_DEVEN_BIT = 6;
   localparam int unsigned CSW_TIP_BIT   = 7;

   // Transfer size encodings
   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   // Address increment modes
   localparam logic [1:0] INC_OFF    = 2'b00;
   localparam logic [1:0] INC_SINGLE = 2'b01;

   // FSM state encodings
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUS  = 1'b1;

   // Registered debug bus command
   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        write;
      logic [31:0] wdata;
   } bus_cmd_t;

   // True for a banked data register word address
   function automatic logic is_bd(input logic [5:0] addr);
      return addr[5:2] == REG_BD_BANK;
   endfunction

endpackage

// File: rtl/opendap_mem_ap_tar_next.sv
// -----------------------------------------------------------------------------
// opendap_mem_ap_tar_next
// Purpose : combinational next-TAR (auto-increment wrapping within 1 KiB) and
//           aligned debug bus address for DRW/BDx accesses.
// Ports   : i_tar      current TAR
//           i_size     CSW.Size
//           i_bd       access targets a banked data register
//           i_bd_idx   banked register index n (BDn)
//           o_tar_inc  TAR after one increment of 1<<Size
//           o_bus_addr byte address to present on the bus
// Config  : OPENDAP_MEM_AP_SUB_WORD_EN enables byte/halfword step/alignment;
//           otherwise step is 4 and bits [1:0] are always cleared.
// -----------------------------------------------------------------------------
module opendap_mem_ap_tar_next
   import opendap_mem_ap_pkg::*;
(
   input  logic [31:0] i_tar,
   input  logic [2:0]  i_size,
   input  logic        i_bd,
   input  logic [1:0]  i_bd_idx,
   output logic [31:0] o_tar_inc,
   output logic [31:0] o_bus_addr
);

   logic [9:0]  w_step;
   logic [31:0] w_align;

`ifndef OPENDAP_MEM_AP_SUB_WORD_EN
   logic w_unused_size;
   assign w_unused_size = ^i_size;
`endif

   // Step size and alignment derived from the transfer size
   always_comb begin
      w_step  = 10'd4;
      w_align = {i_tar[31:2], 2'b00};
`ifdef OPENDAP_MEM_AP_SUB_WORD_EN
      case (i_size)
         SIZE_BYTE: begin
            w_step  = 10'd1;
            w_align = i_tar;
         end
         SIZE_HALF: begin
            w_step  = 10'd2;
            w_align = {i_tar[31:1], 1'b0};
         end
         default: ;
      endcase
`endif
   end

   // Only TAR[9:0] counts; the upper bits stay put so the increment wraps in 1 KiB
   assign o_tar_inc  = {i_tar[31:10], 10'(i_tar[9:0] + w_step)};
   assign o_bus_addr = i_bd ? {i_tar[31:4], i_bd_idx, 2'b00} : w_align;

endmodule

// File: rtl/opendap_mem_ap.sv
// -----------------------------------------------------------------------------
// opendap_mem_ap
// Purpose : MEM-AP behind the SW-DP. Implements CSW, TAR, DRW, BD0-3, CFG,
//           BASE and IDR; DRW/BDx accesses become single req/ack transfers.
// Ports   : swclk, rst (sync, active-high)
//           ap_sel/ap_addr/ap_wdata/ap_wen/ap_ren/ap_abort  from the DP
//           ap_rdata/ap_rdy/ap_err                          to the DP
//           dev_en                                          CSW.DeviceEn
//           bus_addr/bus_size/bus_write/bus_wdata/bus_req   bus master out
//           bus_ack/bus_rdata/bus_err                       bus master in
// Config  : OPENDAP_MEM_AP_SUB_WORD_EN enables byte/halfword transfers; when
//           undefined CSW.Size is fixed at word.
// -----------------------------------------------------------------------------
module opendap_mem_ap
   import opendap_mem_ap_pkg::*;
#(
   parameter logic [7:0]  AP_SEL = 8'd0,
   parameter logic [31:0] IDR    = 32'h0477_0001,
   parameter logic [31:0] BASE   = 32'h0000_0003
)(
   input  logic        swclk,
   input  logic        rst,
   input  logic [7:0]  ap_sel,
   input  logic [5:0]  ap_addr,
   input  logic [31:0] ap_wdata,
   input  logic        ap_wen,
   input  logic        ap_ren,
   input  logic        ap_abort,
   output logic [31:0] ap_rdata,
   output logic        ap_rdy,
   output logic        ap_err,
   input  logic        dev_en,
   output logic [31:0] bus_addr,
   output logic [1:0]  bus_size,
   output logic        bus_write,
   output logic [31:0] bus_wdata,
   output logic        bus_req,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   input  logic        bus_err
);

   logic [0:0]  r_state;
   logic [0:0]  w_state_nxt;
   logic        r_rdy;
   logic        r_err;
   logic        r_req;
   logic [31:0] r_rdata;
   logic [31:0] r_tar;
   logic [2:0]  r_size;
   logic [1:0]  r_inc;
   logic        r_is_drw;
   bus_cmd_t    r_bus;

   logic        w_hit;
   logic        w_rd;
   logic        w_wr;
   logic        w_is_drw;
   logic        w_is_bd;
   logic        w_start;
   logic        w_done;
   logic [31:0] w_csw;
   logic [31:0] w_reg_rdata;
   logic [31:0] w_tar_inc;
   logic [31:0] w_bus_addr;
   logic [2:0]  w_size_wr;

   // Strobes count only when idle, selected and not aborted
   assign w_hit    = r_rdy && (ap_sel == AP_SEL) && !ap_abort;
   assign w_rd     = w_hit && ap_ren;
   assign w_wr     = w_hit && ap_wen;
   assign w_is_drw = (ap_addr == REG_DRW);
   assign w_is_bd  = is_bd(ap_addr);
   assign w_start  = (r_state == ST_IDLE) && (w_rd || w_wr) && (w_is_drw || w_is_bd);
   assign w_done   = (r_state == ST_BUS) && bus_ack && !ap_abort;

   assign w_csw = {24'd0, (r_state == ST_BUS), dev_en, r_inc, 1'b0, r_size};

   // Out-of-range sizes fall back to word
   assign w_size_wr = (ap_wdata[2:0] > SIZE_WORD) ? SIZE_WORD : ap_wdata[2:0];

   opendap_mem_ap_tar_next u_tar_next (
      .i_tar      (r_tar),
      .i_size     (r_size),
      .i_bd       (w_is_bd),
      .i_bd_idx   (ap_addr[1:0]),
      .o_tar_inc  (w_tar_inc),
      .o_bus_addr (w_bus_addr)
   );

   // Register read mux
   always_comb begin
      w_reg_rdata = '0;
      case (ap_addr)
         REG_CSW:  w_reg_rdata = w_csw;
         REG_TAR:  w_reg_rdata = r_tar;
         REG_CFG:  w_reg_rdata = '0;
         REG_BASE: w_reg_rdata = BASE;
         REG_IDR:  w_reg_rdata = IDR;
         default:  w_reg_rdata = '0;
      endcase
   end

   // Next state; abort always returns to idle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_state_nxt = ST_BUS;
         ST_BUS:  if (bus_ack) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
      if (ap_abort) w_state_nxt = ST_IDLE;
   end

   // State register
   always_ff @(posedge swclk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Datapath and registered outputs
   always_ff @(posedge swclk) begin
      if (rst) begin
         r_rdy    <= 1'b1;
         r_err    <= 1'b0;
         r_req    <= 1'b0;
         r_rdata  <= '0;
         r_tar    <= '0;
         r_size   <= SIZE_WORD;
         r_inc    <= INC_OFF;
         r_is_drw <= 1'b0;
         r_bus    <= '{addr: 32'd0, size: 2'(SIZE_WORD), write: 1'b0, wdata: 32'd0};
      end else begin
         r_err <= 1'b0;
         if (ap_abort) begin
            r_rdy <= 1'b1;
            r_req <= 1'b0;
         end else if (w_start) begin
            r_rdy    <= 1'b0;
            r_req    <= 1'b1;
            r_is_drw <= w_is_drw;
            r_bus    <= '{addr: w_bus_addr, size: 2'(r_size), write: ap_wen, wdata: ap_wdata};
         end else if (w_done) begin
            r_rdy <= 1'b1;
            r_req <= 1'b0;
            r_err <= bus_err;
            if (!r_bus.write) r_rdata <= bus_rdata;
            if (r_is_drw && (r_inc == INC_SINGLE) && !bus_err) r_tar <= w_tar_inc;
         end else begin
            // Reads aimed at another AP return zero
            if (r_rdy && ap_ren && (ap_sel != AP_SEL)) r_rdata <= '0;
            if (w_rd) r_rdata <= w_reg_rdata;
            if (w_wr && (ap_addr == REG_TAR)) r_tar <= ap_wdata;
            if (w_wr && (ap_addr == REG_CSW)) begin
`ifdef OPENDAP_MEM_AP_SUB_WORD_EN
               r_size <= w_size_wr;
`endif
               r_inc <= ap_wdata[CSW_INC_LSB + 1] ? INC_OFF : ap_wdata[CSW_INC_LSB +: 2];
            end
         end
      end
   end

`ifndef OPENDAP_MEM_AP_SUB_WORD_EN
   logic w_unused_size_wr;
   assign w_unused_size_wr = ^w_size_wr;
`endif

   assign ap_rdy    = r_rdy;
   assign ap_err    = r_err;
   assign ap_rdata  = r_rdata;
   assign bus_req   = r_req;
   assign bus_addr  = r_bus.addr;
   assign bus_size  = r_bus.size;
   assign bus_write = r_bus.write;
   assign bus_wdata = r_bus.wdata;

endmodule

// File: tb/tb_opendap_mem_ap.sv
`timescale 1ns/1ps
module tb_opendap_mem_ap;

   localparam logic [7:0] AP_SEL = 8'd0;

`ifdef OPENDAP_MEM_AP_SUB_WORD_EN
   localparam logic [31:0] CSW_11   = 32'h0000_0051;
   localparam logic [31:0] B_SIZE   = 32'd0;
   localparam logic [31:0] B_ADDR   = 32'h0000_1003;
   localparam logic [31:0] B_TAR    = 32'h0000_1004;
`else
   localparam logic [31:0] CSW_11   = 32'h0000_0052;
   localparam logic [31:0] B_SIZE   = 32'd2;
   localparam logic [31:0] B_ADDR   = 32'h0000_1000;
   localparam logic [31:0] B_TAR    = 32'h0000_1007;
`endif

   logic        swclk = 1'b0;
   logic        rst;
   logic [7:0]  ap_sel;
   logic [5:0]  ap_addr;
   logic [31:0] ap_wdata;
   logic        ap_wen;
   logic        ap_ren;
   logic        ap_abort;
   logic [31:0] ap_rdata;
   logic        ap_rdy;
   logic        ap_err;
   logic        dev_en;
   logic [31:0] bus_addr;
   logic [1:0]  bus_size;
   logic        bus_write;
   logic [31:0] bus_wdata;
   logic        bus_req;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;

   always #5 swclk = ~swclk;

   opendap_mem_ap #(.AP_SEL(AP_SEL), .IDR(32'h0477_0001), .BASE(32'h0000_0003)) dut (
      .swclk(swclk), .rst(rst),
      .ap_sel(ap_sel), .ap_addr(ap_addr), .ap_wdata(ap_wdata),
      .ap_wen(ap_wen), .ap_ren(ap_ren), .ap_abort(ap_abort),
      .ap_rdata(ap_rdata), .ap_rdy(ap_rdy), .ap_err(ap_err),
      .dev_en(dev_en),
      .bus_addr(bus_addr), .bus_size(bus_size), .bus_write(bus_write),
      .bus_wdata(bus_wdata), .bus_req(bus_req),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        wr;
      logic [7:0]  sel;
      logic [5:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge swclk);
      #1;
   endtask

   task automatic ap_wr(input logic [7:0] sel, input logic [5:0] a, input logic [31:0] d);
      ap_sel = sel; ap_addr = a; ap_wdata = d; ap_wen = 1'b1;
      tick();
      ap_wen = 1'b0;
   endtask

   task automatic ap_rd(input logic [7:0] sel, input logic [5:0] a);
      ap_sel = sel; ap_addr = a; ap_ren = 1'b1;
      tick();
      ap_ren = 1'b0;
   endtask

   // One DRW/BDx transfer; ack arrives after 'delay' extra request cycles
   task automatic xfer(input logic [5:0] a, input logic wr, input logic [31:0] d,
                       input int delay, input logic [31:0] rd, input logic er,
                       output logic [31:0] addr_o, output logic [1:0] size_o,
                       output logic write_o, output logic [31:0] wdata_o,
                       output logic req_o, output int lowcnt);
      ap_sel = AP_SEL; ap_addr = a; ap_wdata = d; ap_wen = wr; ap_ren = !wr;
      tick();
      ap_wen = 1'b0; ap_ren = 1'b0;
      addr_o = bus_addr; size_o = bus_size; write_o = bus_write;
      wdata_o = bus_wdata; req_o = bus_req;
      lowcnt = 0;
      for (int i = 0; i < delay; i++) begin
         if (!ap_rdy) lowcnt++;
         tick();
      end
      if (!ap_rdy) lowcnt++;
      bus_ack = 1'b1; bus_rdata = rd; bus_err = er;
      tick();
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
   endtask

   logic [31:0] x_addr, x_wdata;
   logic [1:0]  x_size;
   logic        x_write, x_req;
   int          x_low;

   initial begin
      rst = 1'b1; ap_sel = AP_SEL; ap_addr = '0; ap_wdata = '0;
      ap_wen = 1'b0; ap_ren = 1'b0; ap_abort = 1'b0; dev_en = 1'b1;
      bus_ack = 1'b0; bus_rdata = '0; bus_err = 1'b0;

      vecs[0]  = '{1'b0, 8'd1,   6'h3F, 32'h0,         32'h0};
      vecs[1]  = '{1'b0, AP_SEL, 6'h3F, 32'h0,         32'h0477_0001};
      vecs[2]  = '{1'b0, AP_SEL, 6'h3E, 32'h0,         32'h0000_0003};
      vecs[3]  = '{1'b0, AP_SEL, 6'h3D, 32'h0,         32'h0};
      vecs[4]  = '{1'b0, AP_SEL, 6'h00, 32'h0,         32'h0000_0042};
      vecs[5]  = '{1'b1, AP_SEL, 6'h01, 32'h1234_5678, 32'h0};
      vecs[6]  = '{1'b0, AP_SEL, 6'h01, 32'h0,         32'h1234_5678};
      vecs[7]  = '{1'b1, AP_SEL, 6'h00, 32'h0000_0012, 32'h0};
      vecs[8]  = '{1'b0, AP_SEL, 6'h00, 32'h0,         32'h0000_0052};
      vecs[9]  = '{1'b1, AP_SEL, 6'h00, 32'h0000_0027, 32'h0};
      vecs[10] = '{1'b0, AP_SEL, 6'h00, 32'h0,         32'h0000_0042};
      vecs[11] = '{1'b1, AP_SEL, 6'h00, 32'h0000_0011, 32'h0};
      vecs[12] = '{1'b0, AP_SEL, 6'h00, 32'h0,         CSW_11};
      vecs[13] = '{1'b1, AP_SEL, 6'h02, 32'hFFFF_FFFF, 32'h0};
      vecs[14] = '{1'b0, AP_SEL, 6'h02, 32'h0,         32'h0};
      vecs[15] = '{1'b1, 8'd5,   6'h01, 32'h0000_DEAD, 32'h0};
      vecs[16] = '{1'b0, AP_SEL, 6'h01, 32'h0,         32'h1234_5678};
      vecs[17] = '{1'b0, AP_SEL, 6'h3C, 32'h0,         32'h0};
      vecs[18] = '{1'b0, AP_SEL, 6'h01, 32'h0,         32'h1234_5678};
      vecs[19] = '{1'b0, 8'd5,   6'h01, 32'h0,         32'h0};

      tick(); tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_rdy",   32'(ap_rdy),    32'd1);
      check("rst_err",   32'(ap_err),    32'd0);
      check("rst_rdata", ap_rdata,       32'd0);
      check("rst_req",   32'(bus_req),   32'd0);
      check("rst_write", 32'(bus_write), 32'd0);
      check("rst_addr",  bus_addr,       32'd0);
      check("rst_wdata", bus_wdata,      32'd0);

      // Register access table
      for (int i = 0; i < 20; i++) begin
         if (vecs[i].wr) begin
            ap_wr(vecs[i].sel, vecs[i].addr, vecs[i].data);
         end else begin
            ap_rd(vecs[i].sel, vecs[i].addr);
            check($sformatf("vec%0d_rdata", i), ap_rdata, vecs[i].exp);
            check($sformatf("vec%0d_rdy", i), 32'(ap_rdy), 32'd1);
            check($sformatf("vec%0d_req", i), 32'(bus_req), 32'd0);
         end
      end

      // DRW access to another AP never reaches the bus
      ap_rd(8'd1, 6'h03);
      check("othersel_req", 32'(bus_req), 32'd0);
      check("othersel_rdy", 32'(ap_rdy), 32'd1);

      // Word write with increment wrapping in 1 KiB
      ap_wr(AP_SEL, 6'h01, 32'h2000_03FC);
      ap_wr(AP_SEL, 6'h00, 32'h0000_0012);
      xfer(6'h03, 1'b1, 32'hCAFE_F00D, 3, 32'h0, 1'b0, x_addr, x_size, x_write, x_wdata, x_req, x_low);
      check("t1_addr",  x_addr,          32'h2000_03FC);
      check("t1_write", 32'(x_write),    32'd1);
      check("t1_wdata", x_wdata,         32'hCAFE_F00D);
      check("t1_size",  32'(x_size),     32'd2);
      check("t1_req",   32'(x_req),      32'd1);
      check("t1_low",   32'(x_low),      32'd4);
      check("t1_rdy",   32'(ap_rdy),     32'd1);
      check("t1_reqoff",32'(bus_req),    32'd0);
      ap_rd(AP_SEL, 6'h01);
      check("t1_tar",   ap_rdata,        32'h2000_0000);

      // Byte read with increment
      ap_wr(AP_SEL, 6'h00, 32'h0000_0010);
      ap_wr(AP_SEL, 6'h01, 32'h0000_1003);
      xfer(6'h03, 1'b0, 32'h0, 0, 32'h1122_3344, 1'b0, x_addr, x_size, x_write, x_wdata, x_req, x_low);
      check("t2_size",  32'(x_size),     B_SIZE);
      check("t2_addr",  x_addr,          B_ADDR);
      check("t2_write", 32'(x_write),    32'd0);
      check("t2_rdata", ap_rdata,        32'h1122_3344);
      tick();
      check("t2_hold",  ap_rdata,        32'h1122_3344);
      ap_rd(AP_SEL, 6'h01);
      check("t2_tar",   ap_rdata,        B_TAR);

      // BD2 read: banked address, no increment
      ap_wr(AP_SEL, 6'h00, 32'h0000_0012);
      ap_wr(AP_SEL, 6'h01, 32'h4000_0010);
      xfer(6'h06, 1'b0, 32'h0, 1, 32'hA5A5_5A5A, 1'b0, x_addr, x_size, x_write, x_wdata, x_req, x_low);
      check("t3_addr",  x_addr,          32'h4000_0018);
      check("t3_rdata", ap_rdata,        32'hA5A5_5A5A);
      ap_rd(AP_SEL, 6'h01);
      check("t3_tar",   ap_rdata,        32'h4000_0010);

      // Bus error: one-cycle ap_err, TAR unchanged
      ap_wr(AP_SEL, 6'h01, 32'h0000_0100);
      xfer(6'h03, 1'b1, 32'h5555_AAAA, 1, 32'h0, 1'b1, x_addr, x_size, x_write, x_wdata, x_req, x_low);
      check("t4_err",   32'(ap_err),     32'd1);
      check("t4_rdy",   32'(ap_rdy),     32'd1);
      tick();
      check("t4_err_1cyc", 32'(ap_err),  32'd0);
      ap_rd(AP_SEL, 6'h01);
      check("t4_tar",   ap_rdata,        32'h0000_0100);

      // Abort of a stalled read
      ap_wr(AP_SEL, 6'h01, 32'h0000_0300);
      ap_rd(AP_SEL, 6'h3F);
      ap_sel = AP_SEL; ap_addr = 6'h03; ap_ren = 1'b1;
      tick();
      ap_ren = 1'b0;
      check("t5_req",   32'(bus_req),    32'd1);
      check("t5_busy",  32'(ap_rdy),     32'd0);
      tick(); tick();
      ap_abort = 1'b1;
      tick();
      ap_abort = 1'b0;
      check("t5_rdy",   32'(ap_rdy),     32'd1);
      check("t5_reqoff",32'(bus_req),    32'd0);
      check("t5_err",   32'(ap_err),     32'd0);
      check("t5_rdata", ap_rdata,        32'h0477_0001);
      ap_rd(AP_SEL, 6'h00);
      check("t5_csw",   ap_rdata,        32'h0000_0052);
      ap_rd(AP_SEL, 6'h01);
      check("t5_tar",   ap_rdata,        32'h0000_0300);

      // Abort coinciding with an erroring ack: no increment, no error
      ap_sel = AP_SEL; ap_addr = 6'h03; ap_ren = 1'b1;
      tick();
      ap_ren = 1'b0;
      ap_abort = 1'b1; bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      tick();
      ap_abort = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
      check("t6_rdy",   32'(ap_rdy),     32'd1);
      check("t6_err",   32'(ap_err),     32'd0);
      check("t6_rdata", ap_rdata,        32'h0000_0300);
      ap_rd(AP_SEL, 6'h01);
      check("t6_tar",   ap_rdata,        32'h0000_0300);

      // Abort together with a strobe drops the strobe
      ap_sel = AP_SEL; ap_addr = 6'h03; ap_ren = 1'b1; ap_abort = 1'b1;
      tick();
      ap_ren = 1'b0; ap_abort = 1'b0;
      check("t7_req",   32'(bus_req),    32'd0);
      check("t7_rdy",   32'(ap_rdy),     32'd1);

      // Reset in the middle of a transfer
      ap_sel = AP_SEL; ap_addr = 6'h03; ap_ren = 1'b1;
      tick();
      ap_ren = 1'b0;
      check("t8_req",   32'(bus_req),    32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t8_reqoff",32'(bus_req),    32'd0);
      check("t8_rdy",   32'(ap_rdy),     32'd1);
      check("t8_rdata", ap_rdata,        32'd0);
      check("t8_addr",  bus_addr,        32'd0);
      ap_rd(AP_SEL, 6'h01);
      check("t8_tar",   ap_rdata,        32'd0);
      ap_rd(AP_SEL, 6'h00);
      check("t8_csw",   ap_rdata,        32'h0000_0042);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
